// File: rtl/mcu_spi_slave_if.sv
// MCU SPI link plus the per-target byte-stream ports of the SPI slave.
interface mcu_spi_slave_if;
    logic       spi_io_ss;
    logic       spi_io_clk;
    logic       spi_io_din;
    logic       spi_io_dout;
    logic       mcu_start;
    logic [7:0] mcu_data_out;
    logic       mcu_sys_strobe;
    logic       mcu_hid_strobe;
    logic       mcu_osd_strobe;
    logic       mcu_sdc_strobe;
    logic [7:0] mcu_sys_din;
    logic [7:0] mcu_hid_din;
    logic [7:0] mcu_osd_din;
    logic [7:0] mcu_sdc_din;

    modport slave (
        input  spi_io_ss, spi_io_clk, spi_io_din,
        input  mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din,
        output spi_io_dout, mcu_start, mcu_data_out,
        output mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe
    );

    modport master (
        output spi_io_ss, spi_io_clk, spi_io_din,
        output mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din,
        input  spi_io_dout, mcu_start, mcu_data_out,
        input  mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe
    );
endinterface

// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: oversampled SPI mode-0 slave. The first byte of a frame
// selects a target; following bytes are strobed to that target and the
// target's registered reply is shifted back on MISO during the next byte.
module mcu_spi_slave #(
    parameter logic [7:0] TGT_SYS = 8'd1,
    parameter logic [7:0] TGT_HID = 8'd2,
    parameter logic [7:0] TGT_OSD = 8'd3,
    parameter logic [7:0] TGT_SDC = 8'd5
) (
    input  logic           clk,
    input  logic           reset,
    mcu_spi_slave_if.slave bus
);
    typedef enum logic [1:0] { IDLE, CMD, DATA } state_t;

    state_t     state;
    logic [1:0] ss_sync;
    logic [2:0] sck_sync;
    logic [1:0] din_sync;
    logic       ss_hi;
    logic       sck_rise;
    logic       sck_fall;
    logic       din_bit;
    logic       armed;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic [7:0] tgt;
    logic [7:0] tx_sr;
    logic       done_q;
    logic       done_d;
    logic       hit_d;
    logic [7:0] reply;

    assign ss_hi    = ss_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign din_bit  = din_sync[1];
    assign rx_byte  = {rx_sr, din_bit};
    assign bus.spi_io_dout = tx_sr[7];

    // Bring the asynchronous SPI pins into the clk domain; sck gets a third flop for edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            ss_sync  <= '0;
            sck_sync <= '0;
            din_sync <= '0;
        end else begin
            ss_sync  <= {ss_sync[0], bus.spi_io_ss};
            sck_sync <= {sck_sync[1:0], bus.spi_io_clk};
            din_sync <= {din_sync[0], bus.spi_io_din};
        end
    end

    // Reply byte offered by the currently addressed target
    always_comb begin
        reply = '0;
        if      (tgt == TGT_SYS) reply = bus.mcu_sys_din;
        else if (tgt == TGT_HID) reply = bus.mcu_hid_din;
        else if (tgt == TGT_OSD) reply = bus.mcu_osd_din;
        else if (tgt == TGT_SDC) reply = bus.mcu_sdc_din;
    end

    // Frame FSM: byte assembly, target routing, strobes and MISO reply shifting
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            armed              <= 1'b0;
            bit_cnt            <= '0;
            rx_sr              <= '0;
            tgt                <= '0;
            tx_sr              <= '0;
            done_q             <= 1'b0;
            done_d             <= 1'b0;
            hit_d              <= 1'b0;
            bus.mcu_start      <= 1'b0;
            bus.mcu_data_out   <= '0;
            bus.mcu_sys_strobe <= 1'b0;
            bus.mcu_hid_strobe <= 1'b0;
            bus.mcu_osd_strobe <= 1'b0;
            bus.mcu_sdc_strobe <= 1'b0;
        end else begin
            bus.mcu_start      <= 1'b0;
            bus.mcu_sys_strobe <= 1'b0;
            bus.mcu_hid_strobe <= 1'b0;
            bus.mcu_osd_strobe <= 1'b0;
            bus.mcu_sdc_strobe <= 1'b0;
            done_q             <= 1'b0;
            // Reply load happens two clocks after the byte completes, so the
            // target has had one clock to register its answer to the strobe.
            done_d <= done_q;
            hit_d  <= bus.mcu_sys_strobe | bus.mcu_hid_strobe |
                      bus.mcu_osd_strobe | bus.mcu_sdc_strobe;

            if (ss_hi) begin
                // armed gates out the tail of a frame that was cut by reset
                state   <= IDLE;
                bit_cnt <= '0;
                tx_sr   <= '0;
                armed   <= 1'b1;
            end else if (armed) begin
                // The fall that closes a byte (bit_cnt back at 0) must not
                // shift, or the freshly loaded reply MSB would be lost.
                if (done_d)
                    tx_sr <= hit_d ? reply : '0;
                else if (sck_fall && bit_cnt != 3'd0)
                    tx_sr <= {tx_sr[6:0], 1'b0};

                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        done_q <= 1'b1;
                        case (state)
                            IDLE: begin
                                tgt   <= rx_byte;
                                state <= CMD;
                            end
                            CMD, DATA: begin
                                bus.mcu_data_out   <= rx_byte;
                                bus.mcu_start      <= (state == CMD);
                                bus.mcu_sys_strobe <= (tgt == TGT_SYS);
                                bus.mcu_hid_strobe <= (tgt == TGT_HID);
                                bus.mcu_osd_strobe <= (tgt == TGT_OSD);
                                bus.mcu_sdc_strobe <= (tgt == TGT_SDC);
                                state              <= DATA;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
        end
    end
endmodule
